// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-path arbiter and its picker.
package uart_pkg;

  localparam int UART_DLEN = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    LOCK = ST_LOCK
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after ptr
// (wrapping) wins. The output is one-hot.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic            any
);

  logic [NREQ-1:0] rot_req;
  logic [NREQ-1:0] rot_pick;

  // Rotate so that ptr sits at bit 0, isolate the lowest set bit, then rotate back.
  assign rot_req  = NREQ'({req, req} >> ptr);
  assign rot_pick = rot_req & (~rot_req + NREQ'(1));
  assign onehot   = NREQ'(({rot_pick, rot_pick} << ptr) >> NREQ);
  assign any      = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART TX byte port. A grant is locked until the owner's
// last byte, a burst cap, or an idle timeout. One IDLE bubble always separates two grants.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DLEN     = UART_DLEN,
  parameter int MAXBURST = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ-1:0]      i_req_last,
  input  logic [NREQ*DLEN-1:0] i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_wvalid,
  output logic [DLEN-1:0]      o_wdata,
  input  logic                 i_wready,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(MAXBURST);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAXBURST - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

  arb_state_e      state;
  logic [NREQ-1:0] grant_q;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   pick_idx;
  logic [BW-1:0]   beat_cnt;
  logic [IW-1:0]   idle_cnt;
  logic [DLEN-1:0] wdata_q;
  logic [DLEN-1:0] owner_data;
  logic [DLEN-1:0] data_arr [NREQ];
  logic [NREQ-1:0] pick_onehot;
  logic            pick_any;
  logic            locked;
  logic            owner_valid;
  logic            owner_last;
  logic            beat;
  logic            burst_done;
  logic            timeout;
  logic            release_lock;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (i_req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      data_arr[k] = i_req_data[k*DLEN +: DLEN];
      if (pick_onehot[k]) pick_idx = PW'(k);
    end
  end

  assign locked       = (state == LOCK);
  assign owner_valid  = i_req_valid[owner];
  assign owner_last   = i_req_last[owner];
  assign owner_data   = data_arr[owner];
  assign o_wvalid     = locked & owner_valid;
  assign o_wdata      = o_wvalid ? owner_data : wdata_q;
  assign beat         = o_wvalid & i_wready;
  assign burst_done   = (beat_cnt == BEAT_LAST);
  // Timeout is judged on the registered count, so a beat arriving in that cycle still goes out.
  assign timeout      = locked & (idle_cnt == IDLE_MAX);
  assign release_lock = (beat & (owner_last | burst_done)) | timeout;
  assign o_grant      = grant_q;
  assign o_busy       = locked;

  always_comb begin
    o_req_ready = '0;
    if (locked) o_req_ready[owner] = i_wready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state   <= LOCK;
            grant_q <= pick_onehot;
            owner   <= pick_idx;
          end
        end
        LOCK: begin
          if (beat) wdata_q <= owner_data;
          if (release_lock) begin
            state    <= IDLE;
            grant_q  <= '0;
            rr_ptr   <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            if (beat && beat_cnt != BEAT_MAX) beat_cnt <= beat_cnt + 1'b1;
            if (owner_valid) idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues drive the inputs,
// an expected byte/grant/gap scoreboard checks the transmit side.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int DLEN     = 8;
  localparam int MAXBURST = 16;
  localparam int TIMEOUT  = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      i_req_last;
  logic [NREQ*DLEN-1:0] i_req_data;
  logic [NREQ-1:0]      o_req_ready;
  logic                 o_wvalid;
  logic [DLEN-1:0]      o_wdata;
  logic                 i_wready;
  logic [NREQ-1:0]      o_grant;
  logic                 o_busy;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .DLEN     (DLEN),
    .MAXBURST (MAXBURST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_wvalid    (o_wvalid),
    .o_wdata     (o_wdata),
    .i_wready    (i_wready),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  logic [DLEN-1:0] src_q      [NREQ][$];
  logic            src_last_q [NREQ][$];
  logic [DLEN-1:0] exp_q[$];
  logic [NREQ-1:0] exp_gnt_q[$];
  int              exp_gap_q[$];
  int              total;
  int              bad;
  int              cyc;
  int              last_beat_cyc;
  int              n;
  logic [NREQ-1:0] prev_grant;
  logic            busy_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_msg(input int k, input logic [DLEN-1:0] b, input logic last);
    src_q[k].push_back(b);
    src_last_q[k].push_back(last);
  endtask

  task automatic refresh();
    for (int k = 0; k < NREQ; k++) begin
      if (src_q[k].size() > 0) begin
        i_req_valid[k]                = 1'b1;
        i_req_data[k*DLEN +: DLEN]    = src_q[k][0];
        i_req_last[k]                 = src_last_q[k][0];
      end else begin
        i_req_valid[k]                = 1'b0;
        i_req_data[k*DLEN +: DLEN]    = '0;
        i_req_last[k]                 = 1'b0;
      end
    end
  endtask

  // Sample on the falling edge, then advance sources just after the rising edge.
  task automatic tick();
    int src;
    src = -1;
    @(negedge clk);
    cyc++;
    busy_s = o_busy;
    if (o_grant != '0 && o_grant != prev_grant) begin
      if (exp_gnt_q.size() > 0) check("grant", 32'(o_grant), 32'(exp_gnt_q.pop_front()));
      else check("grant_extra", 32'(o_grant), 32'd0);
    end
    prev_grant = o_grant;
    if (o_wvalid && i_wready) begin
      for (int k = 0; k < NREQ; k++)
        if (o_req_ready[k] && i_req_valid[k]) src = k;
      if (exp_q.size() > 0) check("byte", 32'(o_wdata), 32'(exp_q.pop_front()));
      else check("byte_extra", 32'(o_wdata), 32'hffff_ffff);
      if (last_beat_cyc >= 0 && exp_gap_q.size() > 0)
        check("gap", cyc - last_beat_cyc, exp_gap_q.pop_front());
      last_beat_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (src >= 0) begin
      void'(src_q[src].pop_front());
      void'(src_last_q[src].pop_front());
    end
    refresh();
  endtask

  task automatic run(input string tag, input int budget);
    int cnt;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((exp_q.size() > 0 || exp_gnt_q.size() > 0 || busy_s) && cnt < budget);
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_grants_left"}, exp_gnt_q.size(), 0);
    check({tag, "_gaps_left"}, exp_gap_q.size(), 0);
    check({tag, "_idle"}, 32'(busy_s), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; last_beat_cyc = -1; n = 0;
    prev_grant = '0; busy_s = 1'b0;
    rst = 1'b1; i_wready = 1'b1;
    i_req_valid = '0; i_req_last = '0; i_req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_wvalid", 32'(o_wvalid), 32'd0);
    check("rst_wdata", 32'(o_wdata), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b0;

    // Round-robin: four 1-byte messages plus a second one from req0.
    last_beat_cyc = -1;
    for (int k = 0; k < NREQ; k++) push_msg(k, 8'(16 + k), 1'b1);
    push_msg(0, 8'h14, 1'b1);
    exp_q     = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    exp_gnt_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_gap_q = '{2, 2, 2, 2};
    refresh();
    run("rr", 100);

    // Message lock: req1 holds the port for three bytes while req2 waits.
    last_beat_cyc = -1;
    push_msg(1, 8'hA1, 1'b0); push_msg(1, 8'hA2, 1'b0); push_msg(1, 8'hA3, 1'b1);
    push_msg(2, 8'hB1, 1'b1);
    exp_q     = '{8'hA1, 8'hA2, 8'hA3, 8'hB1};
    exp_gnt_q = '{4'b0010, 4'b0100};
    exp_gap_q = '{1, 1, 2};
    refresh();
    run("lock", 100);

    // Burst cap: req0 streams 20 bytes without last; req3 joins after req0 is granted.
    last_beat_cyc = -1;
    for (int i = 0; i < 20; i++) push_msg(0, 8'(i), 1'b0);
    exp_q.delete();
    for (int i = 0; i < MAXBURST; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hD3);
    for (int i = MAXBURST; i < 20; i++) exp_q.push_back(8'(i));
    exp_gnt_q = '{4'b0001, 4'b1000, 4'b0001};
    exp_gap_q.delete();
    for (int i = 0; i < MAXBURST - 1; i++) exp_gap_q.push_back(1);
    exp_gap_q.push_back(2); exp_gap_q.push_back(2);
    exp_gap_q.push_back(1); exp_gap_q.push_back(1); exp_gap_q.push_back(1);
    refresh();
    tick();
    push_msg(3, 8'hD3, 1'b1);
    refresh();
    run("burst", 300);

    // Backpressure: i_wready low for 5 cycles after the first byte.
    last_beat_cyc = -1;
    push_msg(1, 8'hC1, 1'b0); push_msg(1, 8'hC2, 1'b0); push_msg(1, 8'hC3, 1'b1);
    exp_q     = '{8'hC1, 8'hC2, 8'hC3};
    exp_gnt_q = '{4'b0010};
    refresh();
    tick();
    tick();
    i_wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2;
      check("bp_wvalid", 32'(o_wvalid), 32'd1);
      check("bp_wdata", 32'(o_wdata), 32'hC2);
      check("bp_ready", 32'(o_req_ready), 32'd0);
    end
    i_wready = 1'b1;
    run("bp", 50);

    // Timeout: req2 sends one byte without last, then goes quiet.
    last_beat_cyc = -1;
    push_msg(2, 8'hE2, 1'b0);
    exp_q     = '{8'hE2};
    exp_gnt_q = '{4'b0100};
    refresh();
    tick();
    tick();
    tick();
    #2;
    check("to_wvalid", 32'(o_wvalid), 32'd0);
    check("to_wdata_hold", 32'(o_wdata), 32'hE2);
    check("to_ready", 32'(o_req_ready), 32'b0100);
    n = busy_s ? 1 : 0;
    while (busy_s && n < 200) begin
      tick();
      if (busy_s) n++;
    end
    check("to_window", 32'((n >= TIMEOUT) && (n <= TIMEOUT + 1)), 32'd1);
    check("to_released", 32'(busy_s), 32'd0);
    check("to_bytes_left", exp_q.size(), 0);

    // After the timeout rr_ptr is 3: all four request, req3 goes first.
    last_beat_cyc = -1;
    for (int k = 0; k < NREQ; k++) push_msg(k, 8'(8'h60 + k), 1'b1);
    exp_q     = '{8'h63, 8'h60, 8'h61, 8'h62};
    exp_gnt_q = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    refresh();
    run("post_to", 100);

    // Reset mid-message while req0 streams.
    last_beat_cyc = -1;
    for (int i = 0; i < 16; i++) push_msg(0, 8'(8'h50 + i), 1'b0);
    exp_q     = '{8'h50, 8'h51, 8'h52};
    exp_gnt_q = '{4'b0001};
    refresh();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(o_grant), 32'd0);
    check("mid_rst_wvalid", 32'(o_wvalid), 32'd0);
    check("mid_rst_ready", 32'(o_req_ready), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_bytes", exp_q.size(), 0);
    for (int k = 0; k < NREQ; k++) begin
      src_q[k].delete();
      src_last_q[k].delete();
    end
    exp_q.delete();
    exp_gnt_q.delete();
    refresh();
    tick();
    rst = 1'b0;
    push_msg(3, 8'h73, 1'b1);
    push_msg(0, 8'h70, 1'b1);
    exp_q     = '{8'h70, 8'h73};
    exp_gnt_q = '{4'b0001, 4'b1000};
    refresh();
    run("post_rst", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
